ppu_special_dispatch: RTL and testbench

- Front-end sequencer placed ahead of the posit arithmetic core in the PPU.
- Classifies each incoming operation as special/trivial or regular.
  - Special/trivial results are produced through the existing special-case handler (handle_special_or_trivial), bypassing the core.
  - Regular operations are issued to the multi-cycle core over a valid/ready request/response pair.
- One operation in flight at a time; results are returned in order on a valid/ready output with backpressure, and usage counters are kept.

---
 rtl/ppu_special_dispatch.sv | 182 ++++++++++++++++++
 tb/tb_ppu_special_dispatch.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_special_dispatch.sv
// ppu_special_dispatch: front-end sequencer ahead of the posit core.
// Special/trivial operations are resolved locally. Regular operations are
// issued to the multi-cycle core one at a time. Results leave in order on a
// valid/ready port, and saturating usage counters are kept.

package ppu_pkg;
  localparam int OP_BITS = 2;
  typedef enum logic [OP_BITS-1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;
endpackage

module ppu_special_dispatch
  import ppu_pkg::*;
#(
  parameter int N     = 16,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_BITS-1:0] in_op,
  input  logic [N-1:0]       in_p1,
  input  logic [N-1:0]       in_p2,
  output logic               core_req_valid,
  input  logic               core_req_ready,
  output logic [OP_BITS-1:0] core_req_op,
  output logic [N-1:0]       core_req_p1,
  output logic [N-1:0]       core_req_p2,
  input  logic               core_rsp_valid,
  output logic               core_rsp_ready,
  input  logic [N-1:0]       core_rsp_pout,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       out_pout,
  output logic               out_special,
  output logic [CNT_W-1:0]   cnt_special,
  output logic [CNT_W-1:0]   cnt_core
);

  localparam logic [N-1:0]     ZERO  = '0;
  localparam logic [N-1:0]     NAR   = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0]     ONE_N = N'(1);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESULT} state_e;

  state_e             r_state;
  state_e             w_next;
  logic               w_is_special;
  logic [N-1:0]       w_special_pout;
  logic [N-1:0]       w_neg_p1;
  logic [N-1:0]       w_neg_p2;
  logic [OP_BITS-1:0] r_op;
  logic [N-1:0]       r_p1;
  logic [N-1:0]       r_p2;
  logic [N-1:0]       r_out_pout;
  logic               r_out_special;
  logic [CNT_W-1:0]   r_cnt_special;
  logic [CNT_W-1:0]   r_cnt_core;

  // Result of an operation that needs no core: NaR dominates, zeros and
  // exact cancellation resolve to the obvious posit.
  function automatic logic [N-1:0] handle_special_or_trivial(
    input logic [OP_BITS-1:0] op,
    input logic [N-1:0]       a,
    input logic [N-1:0]       b
  );
    logic [N-1:0] res;
    res = ZERO;
    if (a == NAR || b == NAR) begin
      res = NAR;
    end else begin
      case (op)
        OP_ADD:  res = (a == ZERO) ? b : ((b == ZERO) ? a : ZERO);
        OP_SUB:  res = (b == ZERO) ? a : ((a == ZERO) ? (~b + ONE_N) : ZERO);
        OP_MUL:  res = ZERO;
        OP_DIV:  res = (b == ZERO) ? NAR : ZERO;
        default: res = ZERO;
      endcase
    end
    return res;
  endfunction

  assign w_neg_p1 = ~in_p1 + ONE_N;
  assign w_neg_p2 = ~in_p2 + ONE_N;

  // Classify the incoming operation and precompute its bypass result.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    w_is_special   = 1'b0;
    w_special_pout = handle_special_or_trivial(in_op, in_p1, in_p2);
    if (in_p1 == ZERO || in_p1 == NAR || in_p2 == ZERO || in_p2 == NAR) begin
      w_is_special = 1'b1;
    end else begin
      case (in_op)
        OP_ADD:  w_is_special = (in_p2 == w_neg_p1);
        OP_SUB:  w_is_special = (in_p2 == in_p1);
        default: w_is_special = 1'b0;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode: one operation in flight, strictly sequential phases.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (in_valid)       w_next = w_is_special ? S_RESULT : S_ISSUE;
      S_ISSUE:  if (core_req_ready) w_next = S_WAIT;
      S_WAIT:   if (core_rsp_valid) w_next = S_RESULT;
      S_RESULT: if (out_ready)      w_next = S_IDLE;
      default:                      w_next = S_IDLE;
    endcase
  end

  // Operand latch, result capture and saturating counters.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every datapath flop is reset here, so an operation abandoned by
    // reset leaves no stale operand or result visible on the ports.
    if (!rst_n) begin
      r_op          <= '0;
      r_p1          <= '0;
      r_p2          <= '0;
      r_out_pout    <= '0;
      r_out_special <= 1'b0;
      r_cnt_special <= '0;
      r_cnt_core    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && w_is_special) begin
            r_out_pout    <= w_special_pout;
            r_out_special <= 1'b1;
          end else if (in_valid) begin
            r_op <= in_op;
            r_p1 <= in_p1;
            r_p2 <= in_p2;
          end
        end
        S_WAIT: begin
          if (core_rsp_valid) begin
            r_out_pout    <= core_rsp_pout;
            r_out_special <= 1'b0;
          end
        end
        S_RESULT: begin
          if (out_ready) begin
            if (r_out_special && r_cnt_special != '1) r_cnt_special <= r_cnt_special + ONE_C;
            if (!r_out_special && r_cnt_core != '1)   r_cnt_core    <= r_cnt_core + ONE_C;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready       = (r_state == S_IDLE);
  assign core_req_valid = (r_state == S_ISSUE);
  assign core_rsp_ready = (r_state == S_WAIT);
  assign out_valid      = (r_state == S_RESULT);
  assign core_req_op    = r_op;
  assign core_req_p1    = r_p1;
  assign core_req_p2    = r_p2;
  assign out_pout       = r_out_pout;
  assign out_special    = r_out_special;
  assign cnt_special    = r_cnt_special;
  assign cnt_core       = r_cnt_core;

endmodule

// File: tb/tb_ppu_special_dispatch.sv
// Self-checking bench for ppu_special_dispatch: directed scenarios plus a
// randomized run, compared every cycle against a transaction-level model.
// CNT_W is shrunk to 8 so counter saturation is reachable quickly.
module tb_ppu_special_dispatch;
  import ppu_pkg::*;

  localparam int N     = 16;
  localparam int CNT_W = 8;
  localparam logic [15:0] NAR = 16'h8000;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [OP_BITS-1:0] in_op;
  logic [N-1:0]       in_p1, in_p2;
  logic               core_req_valid, core_req_ready;
  logic [OP_BITS-1:0] core_req_op;
  logic [N-1:0]       core_req_p1, core_req_p2;
  logic               core_rsp_valid, core_rsp_ready;
  logic [N-1:0]       core_rsp_pout;
  logic               out_valid, out_ready;
  logic [N-1:0]       out_pout;
  logic               out_special;
  logic [CNT_W-1:0]   cnt_special, cnt_core;

  ppu_special_dispatch #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_p1(in_p1), .in_p2(in_p2),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_req_op(core_req_op), .core_req_p1(core_req_p1), .core_req_p2(core_req_p2),
    .core_rsp_valid(core_rsp_valid), .core_rsp_ready(core_rsp_ready),
    .core_rsp_pout(core_rsp_pout),
    .out_valid(out_valid), .out_ready(out_ready), .out_pout(out_pout),
    .out_special(out_special), .cnt_special(cnt_special), .cnt_core(cnt_core)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Transaction-level model: where the single outstanding operation is.
  logic        m_busy, m_need_issue, m_wait_rsp, m_have_result;
  logic [15:0] m_exp_pout;
  logic        m_exp_special;
  logic [1:0]  m_op;
  logic [15:0] m_p1, m_p2;
  int          m_cnt_special, m_cnt_core;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Special rule from plain modular arithmetic: addition cancelling to zero
  // or involving a zero is exactly a+b; likewise a-b for subtraction.
  function automatic logic [16:0] model_special(input logic [1:0] op,
                                                input logic [15:0] a, input logic [15:0] b);
    logic [15:0] sum, dif;
    logic        zero_any;
    sum = a + b;
    dif = a - b;
    zero_any = (a == 16'h0) || (b == 16'h0);
    if (a == NAR || b == NAR) return {1'b1, NAR};
    case (op)
      2'd0: return {zero_any || sum == 16'h0, sum};
      2'd1: return {zero_any || dif == 16'h0, dif};
      2'd2: return {zero_any, 16'h0000};
      default: return {zero_any, (b == 16'h0) ? NAR : 16'h0000};
    endcase
  endfunction

  task automatic model_reset();
    m_busy = 0; m_need_issue = 0; m_wait_rsp = 0; m_have_result = 0;
    m_exp_pout = '0; m_exp_special = 0;
    m_op = '0; m_p1 = '0; m_p2 = '0;
    m_cnt_special = 0; m_cnt_core = 0;
  endtask

  task automatic check_all();
    check("in_ready", 32'(in_ready), 32'(!m_busy));
    check("core_req_valid", 32'(core_req_valid), 32'(m_need_issue));
    check("core_rsp_ready", 32'(core_rsp_ready), 32'(m_wait_rsp));
    check("out_valid", 32'(out_valid), 32'(m_have_result));
    if (m_need_issue) begin
      check("core_req_op", 32'(core_req_op), 32'(m_op));
      check("core_req_p1", 32'(core_req_p1), 32'(m_p1));
      check("core_req_p2", 32'(core_req_p2), 32'(m_p2));
    end
    if (m_have_result) begin
      check("out_pout", 32'(out_pout), 32'(m_exp_pout));
      check("out_special", 32'(out_special), 32'(m_exp_special));
    end
    check("cnt_special", 32'(cnt_special), 32'(m_cnt_special));
    check("cnt_core", 32'(cnt_core), 32'(m_cnt_core));
  endtask

  // Drive one cycle of inputs at the negedge, advance the model across the
  // coming posedge, then check at the following negedge.
  task automatic step(input logic iv, input logic [1:0] op, input logic [15:0] a,
                      input logic [15:0] b, input logic ordy, input logic qrdy,
                      input logic rv, input logic [15:0] rp);
    logic [16:0] sp;
    in_valid = iv; in_op = op; in_p1 = a; in_p2 = b;
    out_ready = ordy; core_req_ready = qrdy;
    core_rsp_valid = rv; core_rsp_pout = rp;
    if (!m_busy && iv) begin
      m_busy = 1;
      sp = model_special(op, a, b);
      if (sp[16]) begin
        m_have_result = 1; m_exp_pout = sp[15:0]; m_exp_special = 1;
      end else begin
        m_need_issue = 1; m_op = op; m_p1 = a; m_p2 = b;
      end
    end else if (m_need_issue && qrdy) begin
      m_need_issue = 0; m_wait_rsp = 1;
    end else if (m_wait_rsp && rv) begin
      m_wait_rsp = 0; m_have_result = 1; m_exp_pout = rp; m_exp_special = 0;
    end else if (m_have_result && ordy) begin
      m_have_result = 0; m_busy = 0;
      if (m_exp_special) m_cnt_special = (m_cnt_special == 255) ? 255 : m_cnt_special + 1;
      else               m_cnt_core    = (m_cnt_core == 255) ? 255 : m_cnt_core + 1;
    end
    @(negedge clk);
    check_all();
  endtask

  function automatic logic [15:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return NAR;
      2: return 16'h4000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic [15:0] a, b;
    rst_n = 0;
    in_valid = 0; in_op = '0; in_p1 = '0; in_p2 = '0;
    out_ready = 0; core_req_ready = 0; core_rsp_valid = 0; core_rsp_pout = '0;
    model_reset();
    #22;
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst core_req_p1", 32'(core_req_p1), 32'd0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check_all();

    // MUL by zero: bypass, latency one, core never asked.
    step(1, OP_MUL, 16'h4000, 16'h0000, 0, 0, 0, 16'h0);
    check("mul0 out_valid", 32'(out_valid), 32'd1);
    check("mul0 out_pout", 32'(out_pout), 32'h0000);
    check("mul0 out_special", 32'(out_special), 32'd1);
    step(0, OP_ADD, 0, 0, 1, 0, 0, 16'h0);
    check("mul0 cnt_special", 32'(cnt_special), 32'd1);

    // ADD cancelling pair then DIV by zero, back to back.
    step(1, OP_ADD, 16'h4000, 16'hC000, 1, 0, 0, 16'h0);
    check("add cancel pout", 32'(out_pout), 32'h0000);
    step(1, OP_DIV, 16'h3000, 16'h0000, 1, 0, 0, 16'h0);
    check("idle after add", 32'(in_ready), 32'd1);
    step(1, OP_DIV, 16'h3000, 16'h0000, 0, 0, 0, 16'h0);
    check("div0 pout", 32'(out_pout), 32'h8000);
    check("div0 special", 32'(out_special), 32'd1);

    // Hold the result for five cycles with a pending request.
    for (int i = 0; i < 5; i++) step(1, OP_MUL, 16'h4000, 16'h4000, 0, 0, 0, 16'h0);
    check("hold pout", 32'(out_pout), 32'h8000);
    check("hold cnt_special", 32'(cnt_special), 32'd2);
    step(0, OP_ADD, 0, 0, 1, 0, 0, 16'h0);
    check("hold released cnt", 32'(cnt_special), 32'd3);

    // Regular MUL through the core with slow request and response.
    step(1, OP_MUL, 16'h4000, 16'h4000, 0, 0, 0, 16'h0);
    step(0, OP_ADD, 0, 0, 0, 0, 1, 16'h1111);
    step(0, OP_ADD, 0, 0, 0, 0, 0, 16'h0);
    check("req_p1 held", 32'(core_req_p1), 32'h4000);
    check("req_p2 held", 32'(core_req_p2), 32'h4000);
    step(0, OP_ADD, 0, 0, 0, 1, 0, 16'h0);
    step(0, OP_ADD, 0, 0, 0, 0, 0, 16'h0);
    step(0, OP_ADD, 0, 0, 0, 0, 0, 16'h0);
    step(0, OP_ADD, 0, 0, 0, 0, 1, 16'h5000);
    check("core pout", 32'(out_pout), 32'h5000);
    check("core special", 32'(out_special), 32'd0);
    step(0, OP_ADD, 0, 0, 1, 0, 0, 16'h0);
    check("cnt_core", 32'(cnt_core), 32'd1);

    // Reset while waiting on the core; a late response must be ignored.
    step(1, OP_DIV, 16'h5000, 16'h4000, 0, 0, 0, 16'h0);
    step(0, OP_ADD, 0, 0, 0, 1, 0, 16'h0);
    check("in wait", 32'(core_rsp_ready), 32'd1);
    #2 rst_n = 0;
    #1;
    check("arst in_ready", 32'(in_ready), 32'd1);
    check("arst rsp_ready", 32'(core_rsp_ready), 32'd0);
    check("arst cnt_core", 32'(cnt_core), 32'd0);
    check("arst req_p1", 32'(core_req_p1), 32'd0);
    model_reset();
    core_rsp_valid = 1; core_rsp_pout = 16'h7777;
    @(negedge clk);
    rst_n = 1;
    step(0, OP_ADD, 0, 0, 1, 1, 1, 16'h7777);
    step(0, OP_ADD, 0, 0, 1, 1, 1, 16'h7777);
    check("ignored rsp", 32'(out_valid), 32'd0);
    step(1, OP_SUB, 16'h1234, 16'h1234, 0, 0, 0, 16'h0);
    check("sub equal pout", 32'(out_pout), 32'h0000);
    step(0, OP_ADD, 0, 0, 1, 0, 0, 16'h0);

    // Saturation of the special counter.
    for (int i = 0; i < 520; i++) step(1, OP_MUL, 16'h0000, 16'h1234, 1, 0, 0, 16'h0);
    check("sat cnt_special", 32'(cnt_special), 32'hFF);

    // Randomized traffic with a random core.
    for (int i = 0; i < 4000; i++) begin
      a = rand_operand();
      case ($urandom_range(0, 3))
        0: b = ~a + 16'h1;
        1: b = a;
        default: b = rand_operand();
      endcase
      step($urandom_range(0, 9) < 6, 2'($urandom), a, b,
           $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
           $urandom_range(0, 9) < 4, 16'($urandom));
    end
    // Drain the last operation so counters settle.
    for (int i = 0; i < 8; i++) step(0, OP_ADD, 0, 0, 1, 1, 1, 16'h2222);
    check("drained", 32'(in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
